l15_resp_serializer: RTL and testbench
======================================

Name: l15_resp_serializer

Overview:
- Parametrised return-path buffer between the L1.5 response interface and a narrower transducer/core datapath.
- Accepts one full-width response per handshake and queues up to DEPTH responses.
- Replays each response as 1..LINE_BITS/BEAT_BITS beats with a valid/ready handshake.
- Lets the L1.5 run with a parametric cacheline size while consumers see a fixed beat width.

Parameters:
- LINE_BITS, 128, width of l15 response data; must be an integer multiple of BEAT_BITS.
- BEAT_BITS, 64, width of one output beat.
- DEPTH, 2, number of buffered responses; power of two, >=2.
- TID_W, 1, thread-id width.
- Derived, not overridable: MAXB = LINE_BITS/BEAT_BITS; BW = clog2(MAXB)+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- l15_val  in  1  L1.5 response valid; held until acked
- l15_returntype  in  4  response type
- l15_threadid  in  TID_W  response thread id
- l15_nbeats  in  BW  beats carried by this response
- l15_data  in  LINE_BITS  response data, beat 0 in bits [BEAT_BITS-1:0]
- l15_req_ack  out  1  one-cycle acknowledge; response captured on this edge
- out_val  out  1  beat valid
- out_rdy  in  1  consumer accepts beat
- out_data  out  BEAT_BITS  current beat
- out_returntype  out  4  head entry returntype
- out_threadid  out  TID_W  head entry thread id
- out_first  out  1  current beat is beat 0
- out_last  out  1  current beat is final beat of entry
- occupancy  out  clog2(DEPTH)+1  entries held

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low. On reset, all state clears: wr_ptr, rd_ptr, count, beat_idx = 0.
- Outputs during and after reset: l15_req_ack = 0, out_val = 0, out_data/out_returntype/out_threadid = 0, out_first = 0, out_last = 0, occupancy = 0.
- Accept:
  - l15_req_ack = l15_val & (count < DEPTH), combinational.
  - When ack is high, header, clamped nbeats and data are written to entry wr_ptr at the rising edge; wr_ptr wraps modulo DEPTH.
  - Upstream rule: val is dropped, or a new response is presented, in the cycle after ack.
- Beat-count clamp: nbeats = 0 is stored as 1; nbeats > MAXB is stored as MAXB.
- Full: ack is withheld while count == DEPTH, even if a pop occurs in the same cycle. No full-cycle bypass.
- Latency: a response captured at edge N gives out_val = 1 from cycle N+1. There is no bypass from l15_data to out_data.
- Output decode:
  - out_val = (count != 0).
  - out_data = head.data[beat_idx*BEAT_BITS +: BEAT_BITS].
  - out_first = out_val & (beat_idx == 0).
  - out_last = out_val & (beat_idx == head.nbeats-1).
  - When empty, all data and meta outputs are forced to 0.
- Advance (out_val & out_rdy):
  - Not last: beat_idx increments.
  - Last: beat_idx returns to 0, rd_ptr increments modulo DEPTH, and the entry is popped.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Hold: while out_val & ~out_rdy, all out_* signals are stable.
- occupancy = count, registered.
- Reset mid-burst: the partially delivered entry and all queued entries are discarded. No beat is emitted until a new ack.

Test Plan:
1. 1-beat response:
   - Stimulus: l15_val = 1, type = 4'h1, tid = 0, nbeats = 1, data = 128'h0000_..._DEAD_BEEF_0123_4567.
   - Required: ack in same cycle; next cycle out_val = 1, out_first = out_last = 1, out_data = 64'hDEADBEEF01234567; popped after one out_rdy cycle.
2. 2-beat line:
   - Stimulus: nbeats = 2, data = {64'hBBBB..., 64'hAAAA...}, out_rdy = 1.
   - Required: beat 0 = 64'hAAAA... with first = 1; beat 1 = 64'hBBBB... with last = 1; occupancy 1 -> 0.
3. Backpressure/full:
   - Stimulus: out_rdy = 0, three back-to-back responses.
   - Required: first two acked; third sees ack = 0 while occupancy = 2; outputs stable; ack comes only in the cycle after the first pop.
4. Simultaneous push and pop:
   - Stimulus: occupancy = 1, consumer takes the last beat while a new l15_val arrives.
   - Required: ack = 1 and occupancy stays 1; next head is the new response.
5. Clamp:
   - Stimulus: nbeats = 0 -> one beat with out_last = 1; nbeats = 3 (MAXB = 2) -> exactly two beats.
6. Reset mid-burst:
   - Stimulus: rst_n low after beat 0 of a 2-beat entry with a second entry queued.
   - Required: out_val = 0 and occupancy = 0 immediately; no stale beats after release.

Source files
------------

// File: rtl/l15_resp_serializer.sv
// Return-path buffer: queues full-width L1.5 responses and replays each
// one as a sequence of narrower beats toward the core/transducer side.
module l15_resp_serializer #(
  parameter int LINE_BITS = 128,
  parameter int BEAT_BITS = 64,
  parameter int DEPTH     = 2,
  parameter int TID_W     = 1,
  localparam int MAXB     = LINE_BITS / BEAT_BITS,
  localparam int BW       = $clog2(MAXB) + 1,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 l15_val,
  input  logic [3:0]           l15_returntype,
  input  logic [TID_W-1:0]     l15_threadid,
  input  logic [BW-1:0]        l15_nbeats,
  input  logic [LINE_BITS-1:0] l15_data,
  output logic                 l15_req_ack,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [BEAT_BITS-1:0] out_data,
  output logic [3:0]           out_returntype,
  output logic [TID_W-1:0]     out_threadid,
  output logic                 out_first,
  output logic                 out_last,
  output logic [CW-1:0]        occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = (MAXB > 1) ? $clog2(MAXB) : 1;

  // Entry storage; data is held as an array of beats so the beat index selects directly.
  logic [MAXB-1:0][BEAT_BITS-1:0] data_q [DEPTH];
  logic [3:0]                     type_q [DEPTH];
  logic [TID_W-1:0]               tid_q  [DEPTH];
  logic [BW-1:0]                  nb_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] beat_idx_q, beat_idx_d;

  logic push, adv, pop, is_last;

  // A zero beat count still carries one beat; anything above the line width is capped.
  function automatic logic [BW-1:0] clamp_nbeats(input logic [BW-1:0] nb);
    if (nb == '0) return BW'(1);
    if (nb > BW'(MAXB)) return BW'(MAXB);
    return nb;
  endfunction

  // Ack is withheld while full, even if the head pops this cycle, and never during reset.
  assign push    = rst_n & l15_val & (count_q < CW'(DEPTH));
  assign out_val = (count_q != '0);
  assign is_last = (BW'(beat_idx_q) == (nb_q[rd_ptr_q] - BW'(1)));
  assign adv     = out_val & out_rdy;
  assign pop     = adv & is_last;

  assign l15_req_ack    = push;
  assign out_data       = out_val ? data_q[rd_ptr_q][beat_idx_q] : '0;
  assign out_returntype = out_val ? type_q[rd_ptr_q] : '0;
  assign out_threadid   = out_val ? tid_q[rd_ptr_q] : '0;
  assign out_first      = out_val & (beat_idx_q == '0);
  assign out_last       = out_val & is_last;
  assign occupancy      = count_q;

  // Capture the presented response into the tail slot on an accepted handshake.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= l15_data;
      type_q[wr_ptr_q] <= l15_returntype;
      tid_q[wr_ptr_q]  <= l15_threadid;
      nb_q[wr_ptr_q]   <= clamp_nbeats(l15_nbeats);
    end
  end

  // Next-state for pointers, occupancy and the beat cursor within the head entry.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_idx_d = beat_idx_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (adv) begin
      if (is_last) begin
        beat_idx_d = '0;
        rd_ptr_d   = rd_ptr_q + PW'(1);
      end else begin
        beat_idx_d = beat_idx_q + IW'(1);
      end
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Control state; reset discards any partially delivered or queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_idx_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_idx_q <= beat_idx_d;
    end
  end

endmodule

// File: tb/tb_l15_resp_serializer.sv
// Bench for l15_resp_serializer: directed scenarios plus a randomized run
// checked against a queue-based model of the response buffer.
module tb_l15_resp_serializer;
  localparam int LINE_BITS = 128;
  localparam int BEAT_BITS = 64;
  localparam int DEPTH     = 2;
  localparam int TID_W     = 1;
  localparam int MAXB      = LINE_BITS / BEAT_BITS;
  localparam int BW        = $clog2(MAXB) + 1;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 l15_val = 1'b0;
  logic [3:0]           l15_returntype = '0;
  logic [TID_W-1:0]     l15_threadid = '0;
  logic [BW-1:0]        l15_nbeats = '0;
  logic [LINE_BITS-1:0] l15_data = '0;
  logic                 l15_req_ack;
  logic                 out_val;
  logic                 out_rdy = 1'b0;
  logic [BEAT_BITS-1:0] out_data;
  logic [3:0]           out_returntype;
  logic [TID_W-1:0]     out_threadid;
  logic                 out_first;
  logic                 out_last;
  logic [CW-1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]           rt;
    logic [TID_W-1:0]     tid;
    int                   nb;
    logic [LINE_BITS-1:0] data;
  } ent_t;
  ent_t mq[$];
  int   midx = 0;

  l15_resp_serializer #(.LINE_BITS(LINE_BITS), .BEAT_BITS(BEAT_BITS), .DEPTH(DEPTH), .TID_W(TID_W)) dut (
    .clk(clk), .rst_n(rst_n), .l15_val(l15_val), .l15_returntype(l15_returntype),
    .l15_threadid(l15_threadid), .l15_nbeats(l15_nbeats), .l15_data(l15_data),
    .l15_req_ack(l15_req_ack), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .out_returntype(out_returntype), .out_threadid(out_threadid), .out_first(out_first),
    .out_last(out_last), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic int clampn(int n);
    return (n == 0) ? 1 : ((n > MAXB) ? MAXB : n);
  endfunction
  function automatic logic e_ack();
    return l15_val && (mq.size() < DEPTH);
  endfunction
  function automatic logic e_val();
    return mq.size() != 0;
  endfunction
  function automatic logic [BEAT_BITS-1:0] e_data();
    if (mq.size() == 0) return '0;
    return BEAT_BITS'(mq[0].data >> (midx * BEAT_BITS));
  endfunction
  function automatic logic e_first();
    return (mq.size() != 0) && (midx == 0);
  endfunction
  function automatic logic e_last();
    if (mq.size() == 0) return 1'b0;
    return midx == mq[0].nb - 1;
  endfunction
  function automatic logic [3:0] e_rt();
    return (mq.size() != 0) ? mq[0].rt : 4'h0;
  endfunction
  function automatic logic [TID_W-1:0] e_tid();
    return (mq.size() != 0) ? mq[0].tid : '0;
  endfunction

  // Advance one clock and apply the buffer rules to the model.
  task automatic step();
    logic push, adv;
    ent_t e;
    push   = e_ack();
    adv    = (mq.size() != 0) && out_rdy;
    e.rt   = l15_returntype;
    e.tid  = l15_threadid;
    e.nb   = clampn(int'(l15_nbeats));
    e.data = l15_data;
    @(posedge clk);
    if (rst_n) begin
      if (adv) begin
        if (midx == mq[0].nb - 1) begin mq.delete(0); midx = 0; end
        else midx++;
      end
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; l15_val = 1'b0; out_rdy = 1'b0;
    mq.delete(); midx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic present(input logic [3:0] rt, input logic [TID_W-1:0] tid, input int nb, input logic [LINE_BITS-1:0] d);
    l15_val = 1'b1; l15_returntype = rt; l15_threadid = tid; l15_nbeats = BW'(nb); l15_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    present(4'h3, 1'b1, 1, {4{32'h5A5A_A5A5}});
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", l15_req_ack); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b exp 0", out_val); end
    checks++; if (out_data !== '0 || out_returntype !== 4'h0 || out_threadid !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h exp 0", out_data, out_returntype, out_threadid); end
    checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", out_first, out_last); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    l15_val = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mq.delete(); midx = 0;
    @(negedge clk);
    checks++; if (out_val !== 1'b0 || occupancy !== '0) begin errors++; $display("FAIL post_reset got val %b occ %0d exp 0 0", out_val, occupancy); end
    step();
  endtask

  task automatic test_one_beat();
    do_reset();
    present(4'h1, 1'b0, 1, 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b1) begin errors++; $display("FAIL one_ack got %b exp 1", l15_req_ack); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL one_nobypass got %b exp 0", out_val); end
    step(); l15_val = 1'b0;
    @(negedge clk);
    checks++; if (out_val !== 1'b1 || out_first !== 1'b1 || out_last !== 1'b1) begin errors++; $display("FAIL one_flags got v%b f%b l%b exp 111", out_val, out_first, out_last); end
    checks++; if (out_data !== 64'hDEADBEEF01234567 || out_returntype !== 4'h1) begin errors++; $display("FAIL one_data got %h/%h exp deadbeef01234567/1", out_data, out_returntype); end
    checks++; if (occupancy !== CW'(1)) begin errors++; $display("FAIL one_occ got %0d exp 1", occupancy); end
    out_rdy = 1'b1; step(); out_rdy = 1'b0;
    @(negedge clk);
    checks++; if (out_val !== 1'b0 || occupancy !== '0) begin errors++; $display("FAIL one_pop got v%b occ %0d exp 0 0", out_val, occupancy); end
    step();
  endtask

  task automatic test_two_beat();
    do_reset();
    present(4'h2, 1'b1, 2, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b1) begin errors++; $display("FAIL two_ack got %b exp 1", l15_req_ack); end
    step(); l15_val = 1'b0;
    @(negedge clk);
    checks++; if (out_data !== 64'hAAAA_AAAA_AAAA_AAAA || out_first !== 1'b1 || out_last !== 1'b0 || occupancy !== CW'(1)) begin errors++; $display("FAIL two_beat0 got %h f%b l%b occ %0d exp aaaa.. 1 0 1", out_data, out_first, out_last, occupancy); end
    step();
    @(negedge clk);
    checks++; if (out_data !== 64'hBBBB_BBBB_BBBB_BBBB || out_first !== 1'b0 || out_last !== 1'b1 || out_threadid !== 1'b1) begin errors++; $display("FAIL two_beat1 got %h f%b l%b tid %b exp bbbb.. 0 1 1", out_data, out_first, out_last, out_threadid); end
    step();
    @(negedge clk);
    checks++; if (out_val !== 1'b0 || occupancy !== '0) begin errors++; $display("FAIL two_empty got v%b occ %0d exp 0 0", out_val, occupancy); end
    out_rdy = 1'b0; step();
  endtask

  task automatic test_full();
    logic [LINE_BITS-1:0] da, db, dc;
    da = {$urandom, $urandom, $urandom, $urandom};
    db = {$urandom, $urandom, $urandom, $urandom};
    dc = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    present(4'h4, 1'b0, 1, da);
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b1) begin errors++; $display("FAIL full_ackA got %b exp 1", l15_req_ack); end
    step(); present(4'h5, 1'b1, 1, db);
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b1) begin errors++; $display("FAIL full_ackB got %b exp 1", l15_req_ack); end
    step(); present(4'h6, 1'b0, 1, dc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (l15_req_ack !== 1'b0 || occupancy !== CW'(2) || out_data !== da[63:0] || out_returntype !== 4'h4) begin errors++; $display("FAIL full_hold%0d got ack %b occ %0d data %h exp 0 2 %h", i, l15_req_ack, occupancy, out_data, da[63:0]); end
      step();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b0) begin errors++; $display("FAIL full_popcycle_ack got %b exp 0", l15_req_ack); end
    step(); out_rdy = 1'b0;
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b1 || occupancy !== CW'(1) || out_data !== db[63:0]) begin errors++; $display("FAIL full_after_pop got ack %b occ %0d data %h exp 1 1 %h", l15_req_ack, occupancy, out_data, db[63:0]); end
    step(); l15_val = 1'b0;
    @(negedge clk);
    checks++; if (occupancy !== CW'(2) || out_returntype !== 4'h5) begin errors++; $display("FAIL full_refill got occ %0d rt %h exp 2 5", occupancy, out_returntype); end
    step();
  endtask

  task automatic test_push_pop();
    logic [LINE_BITS-1:0] db;
    db = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    present(4'h7, 1'b0, 1, {4{32'h1111_2222}});
    step(); present(4'h9, 1'b1, 2, db); out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (l15_req_ack !== 1'b1 || out_last !== 1'b1 || occupancy !== CW'(1)) begin errors++; $display("FAIL pp_cycle got ack %b last %b occ %0d exp 1 1 1", l15_req_ack, out_last, occupancy); end
    step(); l15_val = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    checks++; if (occupancy !== CW'(1) || out_data !== db[63:0] || out_first !== 1'b1 || out_returntype !== 4'h9) begin errors++; $display("FAIL pp_next got occ %0d data %h f%b rt %h exp 1 %h 1 9", occupancy, out_data, out_first, out_returntype, db[63:0]); end
    step();
  endtask

  task automatic test_clamp();
    int beats;
    logic lastseen;
    logic [LINE_BITS-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    present(4'hA, 1'b0, 0, d);
    step(); l15_val = 1'b0;
    @(negedge clk);
    checks++; if (out_first !== 1'b1 || out_last !== 1'b1 || out_data !== d[63:0]) begin errors++; $display("FAIL clamp0 got f%b l%b data %h exp 1 1 %h", out_first, out_last, out_data, d[63:0]); end
    out_rdy = 1'b1; step();
    @(negedge clk);
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL clamp0_pop got %b exp 0", out_val); end
    step();
    present(4'hB, 1'b1, 3, d); out_rdy = 1'b0;
    step(); l15_val = 1'b0; out_rdy = 1'b1;
    beats = 0; lastseen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_val) begin
        checks++; if (out_data !== BEAT_BITS'(d >> (beats * BEAT_BITS))) begin errors++; $display("FAIL clamp3_data%0d got %h exp %h", beats, out_data, BEAT_BITS'(d >> (beats * BEAT_BITS))); end
        beats++; lastseen = out_last;
      end
      step();
    end
    checks++; if (beats != MAXB || lastseen !== 1'b1) begin errors++; $display("FAIL clamp3_count got %0d beats last %b exp %0d 1", beats, lastseen, MAXB); end
    out_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    present(4'hC, 1'b0, 2, {4{32'hCAFE_F00D}});
    step(); present(4'hD, 1'b1, 1, {4{32'h0BAD_0BAD}});
    step(); l15_val = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (out_first !== 1'b1 || occupancy !== CW'(2)) begin errors++; $display("FAIL rmid_pre got f%b occ %0d exp 1 2", out_first, occupancy); end
    step();
    rst_n = 1'b0; mq.delete(); midx = 0;
    #1;
    checks++; if (out_val !== 1'b0 || occupancy !== '0 || out_data !== '0) begin errors++; $display("FAIL rmid_async got v%b occ %0d data %h exp 0 0 0", out_val, occupancy, out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d got %b exp 0", i, out_val); end
      step();
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_random();
    logic acked;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      checks++; if (l15_req_ack !== e_ack() || occupancy !== CW'(mq.size())) begin errors++; $display("FAIL rnd_ctl c%0d got ack %b occ %0d exp %b %0d", c, l15_req_ack, occupancy, e_ack(), mq.size()); end
      checks++; if (out_val !== e_val() || out_first !== e_first() || out_last !== e_last()) begin errors++; $display("FAIL rnd_flags c%0d got v%b f%b l%b exp v%b f%b l%b", c, out_val, out_first, out_last, e_val(), e_first(), e_last()); end
      checks++; if (out_data !== e_data() || out_returntype !== e_rt() || out_threadid !== e_tid()) begin errors++; $display("FAIL rnd_data c%0d got %h/%h/%h exp %h/%h/%h", c, out_data, out_returntype, out_threadid, e_data(), e_rt(), e_tid()); end
      acked = e_ack();
      step();
      if (!l15_val || acked) begin
        l15_val        = ($urandom_range(0, 2) != 0);
        l15_returntype = 4'($urandom);
        l15_threadid   = TID_W'($urandom);
        l15_nbeats     = BW'($urandom_range(0, 3));
        l15_data       = {$urandom, $urandom, $urandom, $urandom};
      end
      out_rdy = ($urandom_range(0, 3) != 0);
    end
    l15_val = 1'b0; out_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_beat();
    test_two_beat();
    test_full();
    test_push_pop();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
